// File: rtl/fsb_ref_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fsb_ref_timer                                                 |
// | Purpose  : FSB-domain timebase. Prescales CLK_FSB into a Tick strobe,    |
// |            raises DRAM refresh requests and tracks how many are owed,    |
// |            and grades bus-cycle timeouts for DTACK/BERR generation.      |
// | Options  : REF_BURST_EN - when defined, up to REF_PEND_MAX refreshes can |
// |            be owed. When undefined, the owed count is a single bit.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fsb_ref_timer #(
  parameter int PRESCALE     = 16,  // CLK_FSB cycles per Tick
  parameter int REF_TICKS    = 24,  // Ticks between refresh events
  parameter int URG_TICKS    = 8,   // Ticks an owed refresh may wait
  parameter int REF_PEND_MAX = 4,   // owed-refresh ceiling (burst build)
  parameter int NTO          = 2,   // number of timeout channels
  parameter int TO_BASE      = 64,  // channel 0 threshold in Ticks
  parameter int PW           = 3    // RefPend width
) (
  input  logic           CLK_FSB,
  input  logic           RES,
  input  logic           BACT,
  input  logic           RefAck,
  output logic           Tick,
  output logic           RefReq,
  output logic           RefUrgent,
  output logic [PW-1:0]  RefPend,
  output logic           RefOvf,
  output logic [NTO-1:0] Timeout
);

  // --------------------------------------------------------------------------
  // Counter widths: each counter just holds its own maximum value.
  // --------------------------------------------------------------------------
  localparam int PSW    = $clog2(PRESCALE);
  localparam int RTW    = $clog2(REF_TICKS);
  localparam int AW     = $clog2(URG_TICKS + 1);
  localparam int TO_MAX = TO_BASE << (NTO - 1);
  localparam int CW     = $clog2(TO_MAX + 1);

  localparam logic [PSW-1:0] PRE_LAST = PSW'(PRESCALE - 1);
  localparam logic [RTW-1:0] RT_LAST  = RTW'(REF_TICKS - 1);
  localparam logic [AW-1:0]  AGE_MAX  = AW'(URG_TICKS);
  localparam logic [CW-1:0]  TO_SAT   = CW'(TO_MAX);

  // Reject parameter sets the counters cannot represent.
  if (PRESCALE < 2 || REF_TICKS < 2 || URG_TICKS < 1 || NTO < 1 || NTO > 8 ||
      TO_BASE < 1 || REF_PEND_MAX < 2 || (1 << PW) <= REF_PEND_MAX) begin : g_param_err
    $error("fsb_ref_timer: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Owed-refresh storage: a count in the burst build, a single flag otherwise.
  // --------------------------------------------------------------------------
`ifdef REF_BURST_EN
  localparam logic [PW-1:0] P_MAX = PW'(REF_PEND_MAX);
  logic [PW-1:0] pend_q, pend_d;
`else
  localparam logic P_MAX = 1'b1;
  logic pend_q, pend_d;
`endif

  logic [PSW-1:0] presc_q, presc_d;
  logic           tick_q, tick_d;
  logic [RTW-1:0] rtk_q, rtk_d;
  logic           ovf_q, ovf_d;
  logic [AW-1:0]  age_q, age_d;
  logic [CW-1:0]  to_q, to_d;
  logic           bact_q, bact_d;

  logic           w_ref_ev;
  logic           w_ack_ok;

  // --------------------------------------------------------------------------
  // Prescaler. tick_q is registered so it is high exactly while the count
  // sits at PRESCALE-1; the first Tick lands PRESCALE cycles after reset.
  // --------------------------------------------------------------------------

  // Next prescale count and the Tick flag that goes with it.
  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PRE_LAST);
  end

  // Prescaler registers.
  always_ff @(posedge CLK_FSB) begin
    if (RES) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // --------------------------------------------------------------------------
  // Refresh interval. A refresh event fires on the Tick that wraps the
  // interval counter, i.e. once every REF_TICKS Ticks.
  // --------------------------------------------------------------------------
  assign w_ref_ev = tick_q && (rtk_q == RT_LAST);

  // Advance the refresh interval counter on each Tick.
  always_comb begin
    rtk_d = rtk_q;
    if (tick_q) begin
      rtk_d = (rtk_q == RT_LAST) ? '0 : rtk_q + 1'b1;
    end
  end

  // Refresh interval register.
  always_ff @(posedge CLK_FSB) begin
    if (RES) begin
      rtk_q <= '0;
    end else begin
      rtk_q <= rtk_d;
    end
  end

  // --------------------------------------------------------------------------
  // Owed refreshes. An acknowledge only counts when something is owed, and a
  // coincident event and acknowledge cancel. An event with the store full is
  // dropped and remembered in the sticky overflow flag.
  // --------------------------------------------------------------------------
  assign w_ack_ok = RefAck && (pend_q != '0);

  // Next owed count and overflow flag.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (w_ref_ev && !w_ack_ok) begin
      if (pend_q == P_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!w_ref_ev && w_ack_ok) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Owed-refresh registers.
  always_ff @(posedge CLK_FSB) begin
    if (RES) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Age of the oldest owed refresh, in Ticks. Any accepted acknowledge
  // restarts it because the next-oldest request is then the one waiting.
  // --------------------------------------------------------------------------

  // Next age: idle at zero, restart on accepted ack, else count and saturate.
  always_comb begin
    age_d = age_q;
    if ((pend_q == '0) || w_ack_ok) begin
      age_d = '0;
    end else if (tick_q && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  // Age register.
  always_ff @(posedge CLK_FSB) begin
    if (RES) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bus-cycle timeout. One counter is shared by all channels; channel i
  // compares against TO_BASE<<i, so lower channels always fire first.
  // --------------------------------------------------------------------------

  // Next timeout count: restart whenever the bus is idle, count Ticks otherwise.
  always_comb begin
    bact_d = BACT;
    to_d   = to_q;
    if (!BACT) begin
      to_d = '0;
    end else if (tick_q && (to_q != TO_SAT)) begin
      to_d = to_q + 1'b1;
    end
  end

  // Timeout counter and bus-active registers.
  always_ff @(posedge CLK_FSB) begin
    if (RES) begin
      to_q   <= '0;
      bact_q <= 1'b0;
    end else begin
      to_q   <= to_d;
      bact_q <= bact_d;
    end
  end

  // Per-channel threshold compare.
  for (genvar i = 0; i < NTO; i++) begin : g_to
    localparam logic [CW-1:0] THR = CW'(TO_BASE << i);
    assign Timeout[i] = bact_q && (to_q >= THR);
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded purely from registers.
  // --------------------------------------------------------------------------

  // Refresh status outputs.
  always_comb begin
    Tick    = tick_q;
    RefReq  = (pend_q != '0);
    RefPend = PW'(pend_q);
    RefOvf  = ovf_q;
`ifdef REF_BURST_EN
    RefUrgent = (age_q == AGE_MAX) || (pend_q == P_MAX);
`else
    RefUrgent = (age_q == AGE_MAX) || (pend_q && ovf_q);
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_fsb_ref_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fsb_ref_timer                                              |
// | Purpose  : Self-checking bench for fsb_ref_timer. Expected outputs are   |
// |            queued per cycle as stimulus is applied and compared when     |
// |            the DUT presents that cycle. Honours REF_BURST_EN.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fsb_ref_timer;

  localparam int PRESCALE     = 4;
  localparam int REF_TICKS    = 3;
  localparam int URG_TICKS    = 2;
  localparam int REF_PEND_MAX = 3;
  localparam int NTO          = 2;
  localparam int TO_BASE      = 2;
  localparam int PW           = 2;

  logic           CLK_FSB = 1'b0;
  logic           RES     = 1'b1;
  logic           BACT    = 1'b0;
  logic           RefAck  = 1'b0;
  logic           Tick;
  logic           RefReq;
  logic           RefUrgent;
  logic [PW-1:0]  RefPend;
  logic           RefOvf;
  logic [NTO-1:0] Timeout;

  fsb_ref_timer #(
    .PRESCALE    (PRESCALE),
    .REF_TICKS   (REF_TICKS),
    .URG_TICKS   (URG_TICKS),
    .REF_PEND_MAX(REF_PEND_MAX),
    .NTO         (NTO),
    .TO_BASE     (TO_BASE),
    .PW          (PW)
  ) dut (
    .CLK_FSB  (CLK_FSB),
    .RES      (RES),
    .BACT     (BACT),
    .RefAck   (RefAck),
    .Tick     (Tick),
    .RefReq   (RefReq),
    .RefUrgent(RefUrgent),
    .RefPend  (RefPend),
    .RefOvf   (RefOvf),
    .Timeout  (Timeout)
  );

  always #5 CLK_FSB = ~CLK_FSB;

  typedef struct {
    int             cyc;
    logic           tick;
    logic           req;
    logic           urg;
    logic [PW-1:0]  pend;
    logic           ovf;
    logic [NTO-1:0] to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(int cyc, bit tick, bit req, bit urg, int pend, bit ovf, int to);
    exp_t e;
    e.cyc  = cyc;
    e.tick = tick;
    e.req  = req;
    e.urg  = urg;
    e.pend = PW'(pend);
    e.ovf  = ovf;
    e.to   = NTO'(to);
    return e;
  endfunction

  // Advance one edge; outputs seen afterwards belong to the next cycle.
  task automatic step();
    @(posedge CLK_FSB);
    #1;
  endtask

  // One edge with RES high; afterwards the DUT shows cycle 1.
  task automatic apply_reset();
    RES = 1'b1;
    @(posedge CLK_FSB);
    #1;
    RES = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    BACT   = 1'b1;
    RefAck = 1'b1;
    apply_reset();
    BACT   = 1'b0;
    RefAck = 1'b0;
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    e = sb.pop_front();
    n_vec++; if (Tick !== e.tick) begin n_err++; $display("FAIL reset_tick: got %b want %b", Tick, e.tick); end
    n_vec++; if (RefReq !== e.req) begin n_err++; $display("FAIL reset_req: got %b want %b", RefReq, e.req); end
    n_vec++; if (RefUrgent !== e.urg) begin n_err++; $display("FAIL reset_urg: got %b want %b", RefUrgent, e.urg); end
    n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL reset_pend: got %0d want %0d", RefPend, e.pend); end
    n_vec++; if (RefOvf !== e.ovf) begin n_err++; $display("FAIL reset_ovf: got %b want %b", RefOvf, e.ovf); end
    n_vec++; if (Timeout !== e.to) begin n_err++; $display("FAIL reset_timeout: got %b want %b", Timeout, e.to); end
  endtask

  // Tick in cycles 4, 8, 12, 16 only.
  task automatic test_tick();
    exp_t e;
    BACT = 1'b0; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 16; c++) begin
      e = sb.pop_front();
      n_vec++; if (Tick !== e.tick) begin n_err++; $display("FAIL tick c%0d: got %b want %b", e.cyc, Tick, e.tick); end
      sb.push_back(mk(c + 1, ((c + 1) % 4) == 0, 0, 0, 0, 0, 0));
      step();
    end
  endtask

  // RefEv at 12 -> request from 13; ack at 15 -> clear from 16; ack at 5 ignored.
  task automatic test_refresh();
    exp_t e;
    bit   r;
    BACT = 1'b0; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 17; c++) begin
      e = sb.pop_front();
      n_vec++; if (RefReq !== e.req) begin n_err++; $display("FAIL refresh_req c%0d: got %b want %b", e.cyc, RefReq, e.req); end
      n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL refresh_pend c%0d: got %0d want %0d", e.cyc, RefPend, e.pend); end
      n_vec++; if (RefUrgent !== e.urg) begin n_err++; $display("FAIL refresh_urg c%0d: got %b want %b", e.cyc, RefUrgent, e.urg); end
      RefAck = (c == 5) || (c == 15);
      r = (c + 1 >= 13) && (c + 1 <= 15);
      sb.push_back(mk(c + 1, 0, r, 0, r ? 1 : 0, 0, 0));
      step();
    end
    RefAck = 1'b0;
  endtask

  // Ack coincident with the second RefEv keeps P=1 and restarts the age.
  task automatic test_urgent();
    exp_t e;
    int   k;
    BACT = 1'b0; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 34; c++) begin
      e = sb.pop_front();
      n_vec++; if (RefReq !== e.req) begin n_err++; $display("FAIL urgent_req c%0d: got %b want %b", e.cyc, RefReq, e.req); end
      n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL urgent_pend c%0d: got %0d want %0d", e.cyc, RefPend, e.pend); end
      n_vec++; if (RefUrgent !== e.urg) begin n_err++; $display("FAIL urgent_urg c%0d: got %b want %b", e.cyc, RefUrgent, e.urg); end
      RefAck = (c == 24);
      k = c + 1;
      sb.push_back(mk(k, 0, k >= 13, ((k >= 21) && (k <= 24)) || (k >= 33), (k >= 13) ? 1 : 0, 0, 0));
      step();
    end
    RefAck = 1'b0;
  endtask

`ifdef REF_BURST_EN
  // Four events with no ack: 1,2,3,3 and overflow; then three acks drain to 0.
  task automatic test_overflow();
    exp_t e;
    int   k;
    int   p;
    BACT = 1'b0; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 58; c++) begin
      e = sb.pop_front();
      n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL ovf_pend c%0d: got %0d want %0d", e.cyc, RefPend, e.pend); end
      n_vec++; if (RefReq !== e.req) begin n_err++; $display("FAIL ovf_req c%0d: got %b want %b", e.cyc, RefReq, e.req); end
      n_vec++; if (RefUrgent !== e.urg) begin n_err++; $display("FAIL ovf_urg c%0d: got %b want %b", e.cyc, RefUrgent, e.urg); end
      n_vec++; if (RefOvf !== e.ovf) begin n_err++; $display("FAIL ovf_flag c%0d: got %b want %b", e.cyc, RefOvf, e.ovf); end
      RefAck = (c == 50) || (c == 52) || (c == 54);
      k = c + 1;
      p = (k <= 12) ? 0 : (k <= 24) ? 1 : (k <= 36) ? 2 : (k <= 50) ? 3 :
          (k <= 52) ? 2 : (k <= 54) ? 1 : 0;
      sb.push_back(mk(k, 0, p != 0, (k >= 21) && (k <= 50), p, k >= 49, 0));
      step();
    end
    RefAck = 1'b0;
  endtask
`else
  // Second event while P=1 sets RefOvf; ack drains; overflow stays sticky.
  task automatic test_overflow();
    exp_t e;
    int   k;
    int   p;
    BACT = 1'b0; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 38; c++) begin
      e = sb.pop_front();
      n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL ovf_pend c%0d: got %0d want %0d", e.cyc, RefPend, e.pend); end
      n_vec++; if (RefReq !== e.req) begin n_err++; $display("FAIL ovf_req c%0d: got %b want %b", e.cyc, RefReq, e.req); end
      n_vec++; if (RefUrgent !== e.urg) begin n_err++; $display("FAIL ovf_urg c%0d: got %b want %b", e.cyc, RefUrgent, e.urg); end
      n_vec++; if (RefOvf !== e.ovf) begin n_err++; $display("FAIL ovf_flag c%0d: got %b want %b", e.cyc, RefOvf, e.ovf); end
      RefAck = (c == 26);
      k = c + 1;
      p = ((k >= 13 && k <= 26) || k >= 37) ? 1 : 0;
      sb.push_back(mk(k, 0, p != 0, (k >= 21 && k <= 26) || k >= 37, p, k >= 25, 0));
      step();
    end
    RefAck = 1'b0;
  endtask
`endif

  // Graded timeouts, drop of BACT, and restart from zero on a new cycle.
  task automatic test_timeout();
    exp_t e;
    int   k;
    int   t;
    BACT = 1'b1; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 30; c++) begin
      e = sb.pop_front();
      n_vec++; if (Timeout !== e.to) begin n_err++; $display("FAIL timeout c%0d: got %b want %b", e.cyc, Timeout, e.to); end
      BACT = !((c == 20) || (c == 21));
      k = c + 1;
      t = (k <= 8) ? 0 : (k <= 16) ? 1 : (k <= 20) ? 3 : (k <= 28) ? 0 : 1;
      sb.push_back(mk(k, 0, 0, 0, 0, 0, t));
      step();
    end
    BACT = 1'b0;
  endtask

  // Mid-operation reset discards everything; Tick restarts PRESCALE later.
  task automatic test_midreset();
    exp_t e;
`ifdef REF_BURST_EN
    int t6_pend = 2;
    bit t6_ovf  = 1'b0;
`else
    int t6_pend = 1;
    bit t6_ovf  = 1'b1;
`endif
    BACT = 1'b1; RefAck = 1'b0;
    apply_reset();
    sb.delete();
    for (int c = 1; c <= 29; c++) step();
    sb.push_back(mk(30, 0, 1, 1, t6_pend, t6_ovf, 3));
    e = sb.pop_front();
    n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL midrst_pre_pend: got %0d want %0d", RefPend, e.pend); end
    n_vec++; if (RefOvf !== e.ovf) begin n_err++; $display("FAIL midrst_pre_ovf: got %b want %b", RefOvf, e.ovf); end
    n_vec++; if (Timeout !== e.to) begin n_err++; $display("FAIL midrst_pre_timeout: got %b want %b", Timeout, e.to); end
    sb.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    apply_reset();
    e = sb.pop_front();
    n_vec++; if (Tick !== e.tick) begin n_err++; $display("FAIL midrst_tick: got %b want %b", Tick, e.tick); end
    n_vec++; if (RefReq !== e.req) begin n_err++; $display("FAIL midrst_req: got %b want %b", RefReq, e.req); end
    n_vec++; if (RefUrgent !== e.urg) begin n_err++; $display("FAIL midrst_urg: got %b want %b", RefUrgent, e.urg); end
    n_vec++; if (RefPend !== e.pend) begin n_err++; $display("FAIL midrst_pend: got %0d want %0d", RefPend, e.pend); end
    n_vec++; if (RefOvf !== e.ovf) begin n_err++; $display("FAIL midrst_ovf: got %b want %b", RefOvf, e.ovf); end
    n_vec++; if (Timeout !== e.to) begin n_err++; $display("FAIL midrst_timeout: got %b want %b", Timeout, e.to); end
    sb.push_back(mk(2, 0, 0, 0, 0, 0, 0));
    step();
    for (int c = 2; c <= 9; c++) begin
      e = sb.pop_front();
      n_vec++; if (Tick !== e.tick) begin n_err++; $display("FAIL midrst_tick c%0d: got %b want %b", e.cyc, Tick, e.tick); end
      sb.push_back(mk(c + 1, ((c + 1) % 4) == 0, 0, 0, 0, 0, 0));
      step();
    end
    BACT = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_refresh();
    test_urgent();
    test_overflow();
    test_timeout();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
